// File: rtl/pipe_clock_controller_if.sv
// Request/status bundle between a debug or test controller and the pipeline
// clock sequencer. The clock and reset stay as plain ports on the sequencer.
interface pipe_clock_controller_if #(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
);
  logic               run;
  logic               halt_req;
  logic               step_req;
  logic               burst_req;
  logic [BURST_W-1:0] burst_len;
  logic               div_load;
  logic [CNT_W-1:0]   div_value;
  logic               cpu_en;
  logic               clk;
  logic [1:0]         state;
  logic               cmd_ack;
  logic [31:0]        cycle_count;

  modport master (
    output run, halt_req, step_req, burst_req, burst_len, div_load, div_value,
    input  cpu_en, clk, state, cmd_ack, cycle_count
  );

  modport slave (
    input  run, halt_req, step_req, burst_req, burst_len, div_load, div_value,
    output cpu_en, clk, state, cmd_ack, cycle_count
  );
endinterface

// File: rtl/pipe_clock_controller.sv
// Run/halt/single-step/burst sequencer for the pipelined core: divides clk_20
// by a programmable ratio and gates one-cycle pipeline enables per state.
module pipe_clock_controller #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 4,
  parameter int BURST_W     = 8
) (
  input logic                     clk_20,
  input logic                     rst,
  pipe_clock_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    BURST = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]   DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0]   DIV_MIN = CNT_W'(2);
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
  localparam logic [BURST_W-1:0] REM_ONE = BURST_W'(1);

  state_t             state_r, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [CNT_W-1:0]   div_r, div_next;
  logic [BURST_W-1:0] remaining, remaining_next;
  logic               clk_r, clk_next;
  logic               cmd_ack_r, ack_next;
  logic [31:0]        cycle_count_r;
  logic               tick;
  logic               cpu_en;

  assign tick   = (cnt == div_r - CNT_ONE);
  assign cpu_en = tick && (state_r != HALT);

  assign bus.cpu_en      = cpu_en;
  assign bus.clk         = clk_r;
  assign bus.state       = state_r;
  assign bus.cmd_ack     = cmd_ack_r;
  assign bus.cycle_count = cycle_count_r;

  // Divider free-runs in every state; a ratio load restarts the count so the
  // new period begins cleanly, while this cycle's tick is still honoured.
  always_comb begin
    div_next = div_r;
    cnt_next = tick ? '0 : cnt + CNT_ONE;
    if (bus.div_load) begin
      div_next = (bus.div_value < DIV_MIN) ? DIV_MIN : bus.div_value;
      cnt_next = '0;
    end
    clk_next = (cnt_next < (div_next >> 1));
  end

  always_comb begin
    state_next     = state_r;
    remaining_next = remaining;
    ack_next       = 1'b0;
    unique case (state_r)
      HALT: begin
        if (bus.halt_req) begin
          ack_next = 1'b1;
        end else if (bus.step_req) begin
          state_next = STEP;
          ack_next   = 1'b1;
        end else if (bus.burst_req && (bus.burst_len != '0)) begin
          state_next     = BURST;
          remaining_next = bus.burst_len;
          ack_next       = 1'b1;
        end else if (bus.run) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (bus.halt_req) begin
          state_next = HALT;
          ack_next   = 1'b1;
        end else if (!bus.run) begin
          state_next = HALT;
        end
      end
      STEP: begin
        if (bus.halt_req) begin
          state_next = HALT;
          ack_next   = 1'b1;
        end else if (tick) begin
          state_next = HALT;
        end
      end
      BURST: begin
        if (bus.halt_req) begin
          state_next     = HALT;
          remaining_next = '0;
          ack_next       = 1'b1;
        end else if (tick) begin
          if (remaining <= REM_ONE) begin
            state_next     = HALT;
            remaining_next = '0;
          end else begin
            remaining_next = remaining - REM_ONE;
          end
        end
      end
      default: state_next = HALT;
    endcase
  end

  always_ff @(posedge clk_20) begin
    if (rst) begin
      state_r       <= HALT;
      cnt           <= '0;
      div_r         <= DIV_RST;
      remaining     <= '0;
      clk_r         <= 1'b1;
      cmd_ack_r     <= 1'b0;
      cycle_count_r <= '0;
    end else begin
      state_r   <= state_next;
      cnt       <= cnt_next;
      div_r     <= div_next;
      remaining <= remaining_next;
      clk_r     <= clk_next;
      cmd_ack_r <= ack_next;
      if (cpu_en) begin
        cycle_count_r <= cycle_count_r + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_clock_controller.sv
// Scoreboard bench for pipe_clock_controller: expected cpu_en pulses and
// cmd_ack pulses are queued by edge number when commands are driven.
module tb_pipe_clock_controller;
  localparam int CNT_W   = 16;
  localparam int BURST_W = 8;

  logic clk_20 = 1'b0;
  logic rst;

  pipe_clock_controller_if #(.CNT_W(CNT_W), .BURST_W(BURST_W)) bus ();

  pipe_clock_controller #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (4),
    .BURST_W     (BURST_W)
  ) dut (
    .clk_20 (clk_20),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_20 = ~clk_20;

  typedef struct {
    int unsigned edge_no;
    int unsigned count;
  } pulse_t;

  pulse_t      pulse_q[$];
  int unsigned ack_q[$];
  int unsigned n_checks  = 0;
  int unsigned n_errors  = 0;
  int unsigned edge_no   = 0;
  int unsigned ref_edge  = 0;
  int unsigned cur_div   = 4;
  int unsigned exp_count = 0;
  int unsigned last;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_no);
    end
  endtask

  // Advance to the next negedge; edge_no then equals the number of posedges seen.
  task automatic next_cycle();
    pulse_t      p;
    int unsigned a;
    @(negedge clk_20);
    edge_no++;
    if (pulse_q.size() != 0 && pulse_q[0].edge_no == edge_no) begin
      p = pulse_q.pop_front();
      check("cpu_en", bus.cpu_en, 1);
      check("cycle_count_at_pulse", bus.cycle_count, p.count);
    end else if (bus.cpu_en) begin
      check("cpu_en_extra", bus.cpu_en, 0);
    end
    if (ack_q.size() != 0 && ack_q[0] == edge_no) begin
      a = ack_q.pop_front();
      check("cmd_ack", bus.cmd_ack, 1);
    end else if (bus.cmd_ack) begin
      check("cmd_ack_extra", bus.cmd_ack, 0);
    end
  endtask

  // First edge after 'after' at which the divider count sits at div-1.
  function automatic int unsigned next_tick(input int unsigned after);
    int unsigned r;
    r = (after - ref_edge) % cur_div;
    return (r == cur_div - 1) ? after + cur_div : after + (cur_div - 1 - r);
  endfunction

  task automatic push_pulses(input int unsigned n, output int unsigned last_edge);
    pulse_t      p;
    int unsigned t;
    t = next_tick(edge_no);
    last_edge = t;
    for (int unsigned i = 0; i < n; i++) begin
      p.edge_no = t;
      p.count   = exp_count;
      pulse_q.push_back(p);
      exp_count++;
      last_edge = t;
      t += cur_div;
    end
  endtask

  task automatic wait_to(input int unsigned e, input bit chk_clk);
    while (edge_no < e) begin
      next_cycle();
      if (chk_clk)
        check("clk", bus.clk, ((edge_no - ref_edge) % cur_div) < (cur_div / 2));
    end
  endtask

  task automatic align0();
    for (int i = 0; i < 64; i++) begin
      if (((edge_no - ref_edge) % cur_div) == 0) break;
      next_cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.run       = 1'b0;
    bus.halt_req  = 1'b0;
    bus.step_req  = 1'b0;
    bus.burst_req = 1'b0;
    bus.burst_len = '0;
    bus.div_load  = 1'b0;
    bus.div_value = '0;
    repeat (3) next_cycle();

    check("rst_state", bus.state, 0);
    check("rst_clk", bus.clk, 1);
    check("rst_cpu_en", bus.cpu_en, 0);
    check("rst_cmd_ack", bus.cmd_ack, 0);
    check("rst_cycle_count", bus.cycle_count, 0);
    ref_edge = edge_no;
    cur_div  = 4;

    // Continuous run at the reset ratio.
    rst     = 1'b0;
    bus.run = 1'b1;
    push_pulses(5, last);
    wait_to(last, 1'b1);
    check("run_state", bus.state, 1);
    bus.run = 1'b0;
    next_cycle();
    check("run_off_state", bus.state, 0);

    // Single step, with a second step issued while stepping.
    align0();
    bus.step_req = 1'b1;
    ack_q.push_back(edge_no + 1);
    push_pulses(1, last);
    next_cycle();
    check("step_state", bus.state, 2);
    next_cycle();
    bus.step_req = 1'b0;
    wait_to(last, 1'b0);
    next_cycle();
    check("step_done_state", bus.state, 0);
    repeat (6) next_cycle();

    // Halt while halted: acked, no state change.
    bus.halt_req = 1'b1;
    ack_q.push_back(edge_no + 1);
    next_cycle();
    bus.halt_req = 1'b0;
    check("halt_in_halt_state", bus.state, 0);

    // Burst of 5, then a zero-length burst request.
    align0();
    bus.burst_req = 1'b1;
    bus.burst_len = 8'd5;
    ack_q.push_back(edge_no + 1);
    push_pulses(5, last);
    next_cycle();
    bus.burst_req = 1'b0;
    check("burst_state", bus.state, 3);
    wait_to(last, 1'b0);
    next_cycle();
    check("burst_done_state", bus.state, 0);
    check("burst_count", bus.cycle_count, exp_count);
    repeat (8) next_cycle();
    bus.burst_req = 1'b1;
    bus.burst_len = '0;
    next_cycle();
    bus.burst_req = 1'b0;
    next_cycle();
    check("burst0_state", bus.state, 0);

    // Ratio 1 clamps to 2, then reload to 7 while running.
    bus.div_load  = 1'b1;
    bus.div_value = 16'd1;
    next_cycle();
    bus.div_load = 1'b0;
    ref_edge = edge_no;
    cur_div  = 2;
    bus.run  = 1'b1;
    push_pulses(4, last);
    wait_to(last, 1'b1);
    bus.div_load  = 1'b1;
    bus.div_value = 16'd7;
    next_cycle();
    bus.div_load = 1'b0;
    ref_edge = edge_no;
    cur_div  = 7;
    check("div7_clk_restart", bus.clk, 1);
    push_pulses(3, last);
    wait_to(last, 1'b1);
    check("div7_run_state", bus.state, 1);
    bus.run = 1'b0;
    next_cycle();
    check("div7_halt_state", bus.state, 0);

    // Step aborted by halt before its tick.
    align0();
    bus.step_req = 1'b1;
    ack_q.push_back(edge_no + 1);
    next_cycle();
    bus.step_req = 1'b0;
    bus.halt_req = 1'b1;
    ack_q.push_back(edge_no + 1);
    next_cycle();
    bus.halt_req = 1'b0;
    check("step_abort_state", bus.state, 0);
    repeat (8) next_cycle();

    // Step with run held: one HALT cycle, then RUN.
    align0();
    bus.step_req = 1'b1;
    bus.run      = 1'b1;
    ack_q.push_back(edge_no + 1);
    push_pulses(1, last);
    next_cycle();
    bus.step_req = 1'b0;
    wait_to(last, 1'b0);
    next_cycle();
    check("step_run_gap_state", bus.state, 0);
    next_cycle();
    check("step_run_resume_state", bus.state, 1);
    bus.run = 1'b0;
    next_cycle();
    check("step_run_stop_state", bus.state, 0);
    repeat (8) next_cycle();

    // Burst of 10 halted in the cycle of its 2nd pulse.
    align0();
    bus.burst_req = 1'b1;
    bus.burst_len = 8'd10;
    ack_q.push_back(edge_no + 1);
    push_pulses(2, last);
    next_cycle();
    bus.burst_req = 1'b0;
    wait_to(last, 1'b0);
    bus.halt_req = 1'b1;
    ack_q.push_back(edge_no + 1);
    next_cycle();
    bus.halt_req = 1'b0;
    check("burst_halt_state", bus.state, 0);
    check("burst_halt_count", bus.cycle_count, exp_count);
    repeat (16) next_cycle();

    // Reset in the middle of a div-7 run.
    align0();
    bus.run = 1'b1;
    push_pulses(1, last);
    wait_to(last + 3, 1'b0);
    rst = 1'b1;
    next_cycle();
    check("mid_rst_state", bus.state, 0);
    check("mid_rst_clk", bus.clk, 1);
    check("mid_rst_cpu_en", bus.cpu_en, 0);
    check("mid_rst_cmd_ack", bus.cmd_ack, 0);
    check("mid_rst_cycle_count", bus.cycle_count, 0);
    rst       = 1'b0;
    exp_count = 0;
    ref_edge  = edge_no;
    cur_div   = 4;
    push_pulses(2, last);
    wait_to(last, 1'b1);
    bus.run = 1'b0;
    next_cycle();
    check("post_rst_halt_state", bus.state, 0);

    repeat (4) next_cycle();
    check("pulse_q_drained", pulse_q.size(), 0);
    check("ack_q_drained", ack_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
